ad2s1210_spi_engine: RTL

AD2S1210_SPI_ENGINE -- requirements
Module: ad2s1210_spi_engine

---
 rtl/ad2s1210_pkg.sv | 24 ++
 rtl/ad2s1210_spi_engine_if.sv | 11 +
 rtl/ad2s1210_sclk_gen.sv | 25 ++
 rtl/ad2s1210_spi_engine.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/ad2s1210_pkg.sv
// Shared types and constants for the AD2S1210 SPI engine.
package ad2s1210_pkg;

   // Frame sequencer states
   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      SETUP      = 3'd1,
      SHIFT_LOW  = 3'd2,
      SHIFT_HIGH = 3'd3,
      HOLD       = 3'd4,
      DONE       = 3'd5
   } state_t;

   // Converter register addresses
   localparam logic [7:0] REG_POSITION = 8'h80;
   localparam logic [7:0] REG_VELOCITY = 8'h82;
   localparam logic [7:0] REG_FAULT    = 8'hFF;

   // Default frame timing
   localparam int DEFAULT_DATA_WIDTH   = 8;
   localparam int DEFAULT_SETUP_CYCLES = 4;
   localparam int DEFAULT_HOLD_CYCLES  = 4;

endpackage

// File: rtl/ad2s1210_spi_engine_if.sv
// Minimal valid/ready byte stream used for the transfer and received paths.
interface axi_stream #(
   parameter int WIDTH = 8
) ();
   logic             valid;
   logic             ready;
   logic [WIDTH-1:0] data;

   modport master (output valid, output data, input ready);
   modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/ad2s1210_sclk_gen.sv
// Half-period timer for sclk: counts while running, ticks on the last cycle
// of each half period and restarts itself on the tick.
module ad2s1210_sclk_gen (
   input  logic       clock,
   input  logic       reset,
   input  logic       run,
   input  logic [7:0] half_period,   // always >= 1
   output logic       tick
);
   logic [7:0] cnt_q, cnt_d;

   assign tick = run && (cnt_q == half_period - 8'd1);

   // Counter restarts whenever the shifter is not running or a half period ends
   always_comb begin
      cnt_d = cnt_q + 8'd1;
      if (!run || tick) cnt_d = 8'd0;
   end

   // Counter register with synchronous active-low reset
   always_ff @(posedge clock) begin
      if (!reset) cnt_q <= 8'd0;
      else        cnt_q <= cnt_d;
   end
endmodule

// File: rtl/ad2s1210_spi_engine.sv
// One-byte SPI frame engine for the AD2S1210: frames a transfer with wr_n,
// shifts MSB first on sclk, samples sdo on each sclk rise and reports the
// received byte with a single-cycle valid pulse.
module ad2s1210_spi_engine
   import ad2s1210_pkg::*;
#(
   parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
   parameter int SETUP_CYCLES = DEFAULT_SETUP_CYCLES,
   parameter int HOLD_CYCLES  = DEFAULT_HOLD_CYCLES
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] clock_divider,
   axi_stream.slave   transfer,
   axi_stream.master  received,
   output logic       sclk,
   output logic       sdi,
   input  logic       sdo,
   output logic       wr_n,
   output logic       busy
);
   localparam int BIT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam int PH_MAX = (SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES;
   localparam int PH_W   = $clog2(PH_MAX + 1);

   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] tx_q, tx_d;
   logic [DATA_WIDTH-1:0] rx_q, rx_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic [7:0]            div_q, div_d;
   logic [BIT_W-1:0]      bit_q, bit_d;
   logic [PH_W-1:0]       phase_q, phase_d;
   logic                  sclk_q, sclk_d;
   logic                  sdi_q, sdi_d;
   logic                  wr_n_q, wr_n_d;
   logic                  busy_q, busy_d;
   logic                  ready_q, ready_d;
   logic                  valid_q, valid_d;
   logic                  tick;

   ad2s1210_sclk_gen u_sclk_gen (
      .clock       (clock),
      .reset       (reset),
      .run         ((state_q == SHIFT_LOW) || (state_q == SHIFT_HIGH)),
      .half_period (div_q),
      .tick        (tick)
   );

   assign sclk           = sclk_q;
   assign sdi            = sdi_q;
   assign wr_n           = wr_n_q;
   assign busy           = busy_q;
   assign transfer.ready = ready_q;
   assign received.valid = valid_q;
   assign received.data  = rdata_q;

   // Next-state and datapath decode; the divider is frozen at accept
   always_comb begin
      state_d = state_q;
      tx_d    = tx_q;
      rx_d    = rx_q;
      rdata_d = rdata_q;
      div_d   = div_q;
      bit_d   = bit_q;
      phase_d = phase_q;
      sclk_d  = sclk_q;
      sdi_d   = sdi_q;
      wr_n_d  = wr_n_q;
      case (state_q)
         IDLE: begin
            if (transfer.valid && ready_q) begin
               tx_d    = transfer.data;
               rx_d    = '0;
               wr_n_d  = 1'b0;
               bit_d   = '0;
               phase_d = '0;
               div_d   = (clock_divider == 8'd0) ? 8'd1 : clock_divider;
               state_d = SETUP;
            end
         end
         SETUP: begin
            if (phase_q == PH_W'(SETUP_CYCLES - 1)) begin
               sdi_d   = tx_q[DATA_WIDTH-1];
               sclk_d  = 1'b0;
               state_d = SHIFT_LOW;
            end else begin
               phase_d = phase_q + PH_W'(1);
            end
         end
         SHIFT_LOW: begin
            if (tick) begin
               sclk_d  = 1'b1;
               rx_d    = {rx_q[DATA_WIDTH-2:0], sdo};
               state_d = SHIFT_HIGH;
            end
         end
         SHIFT_HIGH: begin
            if (tick) begin
               if (bit_q == BIT_W'(DATA_WIDTH - 1)) begin
                  phase_d = '0;
                  state_d = HOLD;
               end else begin
                  tx_d    = {tx_q[DATA_WIDTH-2:0], 1'b0};
                  sdi_d   = tx_q[DATA_WIDTH-2];
                  sclk_d  = 1'b0;
                  bit_d   = bit_q + BIT_W'(1);
                  state_d = SHIFT_LOW;
               end
            end
         end
         HOLD: begin
            if (phase_q == PH_W'(HOLD_CYCLES - 1)) begin
               wr_n_d  = 1'b1;
               sdi_d   = 1'b0;
               rdata_d = rx_q;
               state_d = DONE;
            end else begin
               phase_d = phase_q + PH_W'(1);
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      busy_d  = (state_d != IDLE);
      ready_d = (state_d == IDLE);
      valid_d = (state_d == DONE);
   end

   // State and output registers; reset aborts any frame in progress
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q <= IDLE;
         tx_q    <= '0;
         rx_q    <= '0;
         rdata_q <= '0;
         div_q   <= 8'd1;
         bit_q   <= '0;
         phase_q <= '0;
         sclk_q  <= 1'b1;
         sdi_q   <= 1'b0;
         wr_n_q  <= 1'b1;
         busy_q  <= 1'b0;
         ready_q <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         tx_q    <= tx_d;
         rx_q    <= rx_d;
         rdata_q <= rdata_d;
         div_q   <= div_d;
         bit_q   <= bit_d;
         phase_q <= phase_d;
         sclk_q  <= sclk_d;
         sdi_q   <= sdi_d;
         wr_n_q  <= wr_n_d;
         busy_q  <= busy_d;
         ready_q <= ready_d;
         valid_q <= valid_d;
      end
   end
endmodule
